// File: rtl/strob_former_if.sv
// Strobe former control/status bundle.
// master: the requester driving start/abort/delay/width.
// slave:  the strobe former itself.
interface strob_former_if #(
    parameter int CNT_W = 16
);
    logic             i_start_str;
    logic             i_abort;
    logic [CNT_W-1:0] i_delay;
    logic [CNT_W-1:0] i_width;
    logic             o_strob;
    logic             o_busy;
    logic             o_done;
    logic [15:0]      o_cnt;

    modport master (
        output i_start_str, i_abort, i_delay, i_width,
        input  o_strob, o_busy, o_done, o_cnt
    );

    modport slave (
        input  i_start_str, i_abort, i_delay, i_width,
        output o_strob, o_busy, o_done, o_cnt
    );
endinterface

// File: rtl/strob_former.sv
// strob_former: on a start pulse, waits a programmable delay, then drives a
// registered strobe for a programmable width, pulses o_done, and holds off new
// starts for P_GAP idle cycles. Counts issued strobes in a 16-bit wrapping
// counter.
// Optional build macro STROB_RETRIG_EN: a start during the strobe reloads the
// remaining width with the new i_width (strobe extended, no extra count).
module strob_former #(
    parameter int CNT_W = 16,
    parameter int P_GAP = 4
) (
    input  logic          iclk,
    input  logic          irst,
    strob_former_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DELAY, ACTIVE, GAP} state_t;

    // Gap timer only needs to hold P_GAP; keep at least one bit when P_GAP == 0.
    localparam int              GAP_W  = (P_GAP > 0) ? $clog2(P_GAP + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LD = GAP_W'(P_GAP);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] tmr_q, tmr_d;     // remaining delay, then remaining width
    logic [CNT_W-1:0] wlat_q, wlat_d;   // width latched at start
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             strob_q, strob_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [15:0]      cnt_q, cnt_d;

    logic start_ok;
    logic retrig;

    // A start is only meaningful when it carries a non-zero width.
    assign start_ok = bus.i_start_str && (bus.i_width != '0);

`ifdef STROB_RETRIG_EN
    assign retrig = start_ok && (state_q == ACTIVE);
`else
    assign retrig = 1'b0;
`endif

    // Next-state and registered-output computation.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        wlat_d  = wlat_q;
        gap_d   = gap_q;
        strob_d = strob_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    wlat_d = bus.i_width;
                    if (bus.i_delay != '0) begin
                        state_d = DELAY;
                        tmr_d   = bus.i_delay;
                    end else begin
                        // Zero delay: strobe rises on the start edge itself.
                        state_d = ACTIVE;
                        tmr_d   = bus.i_width;
                        strob_d = 1'b1;
                        cnt_d   = cnt_q + 16'd1;
                    end
                end
            end
            DELAY: begin
                if (tmr_q == ONE) begin
                    state_d = ACTIVE;
                    tmr_d   = wlat_q;
                    strob_d = 1'b1;
                    cnt_d   = cnt_q + 16'd1;
                end else begin
                    tmr_d = tmr_q - ONE;
                end
            end
            ACTIVE: begin
                if (retrig) begin
                    // Strobe stays high for i_width more cycles from the next one.
                    tmr_d = bus.i_width;
                end else if (tmr_q == ONE) begin
                    strob_d = 1'b0;
                    done_d  = 1'b1;
                    if (P_GAP == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = GAP;
                        gap_d   = GAP_LD;
                    end
                end else begin
                    tmr_d = tmr_q - ONE;
                end
            end
            GAP: begin
                if (gap_q <= GAP_W'(1)) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides everything, including a start in the same cycle.
        if (bus.i_abort) begin
            state_d = IDLE;
            tmr_d   = tmr_q;
            wlat_d  = wlat_q;
            strob_d = 1'b0;
            done_d  = 1'b0;
            cnt_d   = cnt_q;
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            wlat_q  <= '0;
            gap_q   <= '0;
            strob_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            wlat_q  <= wlat_d;
            gap_q   <= gap_d;
            strob_q <= strob_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.o_strob = strob_q;
    assign bus.o_busy  = busy_q;
    assign bus.o_done  = done_q;
    assign bus.o_cnt   = cnt_q;
endmodule

// File: doc/strob_former.md
STROB_FORMER -- requirements
Module: strob_former

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of delay/width counters and inputs.
REQ-002 SHALL have parameter P_GAP, default 4: minimum idle cycles after a strobe before the next start is accepted; 0 allowed.
REQ-003 SHALL have port iclk, input, 1: sole clock; all state changes on its rising edge.
REQ-004 SHALL have port irst, input, 1: asynchronous active-high reset.
REQ-005 SHALL have port i_start_str, input, 1: one-cycle start pulse requesting a strobe.
REQ-006 SHALL have port i_abort, input, 1: terminate any operation, return to idle.
REQ-007 SHALL have port i_delay, input, CNT_W: cycles from start to strobe rise; sampled at start.
REQ-008 SHALL have port i_width, input, CNT_W: strobe high length in cycles; sampled at start.
REQ-009 SHALL have port o_strob, output, 1: registered strobe level.
REQ-010 SHALL have port o_busy, output, 1: high in every non-IDLE state.
REQ-011 SHALL have port o_done, output, 1: one-cycle pulse on normal completion.
REQ-012 SHALL have port o_cnt, output, 16: count of strobes issued.

Function
REQ-013 SHALL implement states IDLE, DELAY, ACTIVE, GAP; all outputs registered.
REQ-014 IDLE: start high with i_width != 0 SHALL latch i_delay/i_width; go to DELAY if latched delay != 0, else ACTIVE.
REQ-015 Start in IDLE with i_width == 0 SHALL be ignored: no state change, no o_done, o_cnt unchanged.
REQ-016 Start in cycle N SHALL give o_strob high first in cycle N+1+D (D = latched delay), high for exactly W consecutive cycles (W = latched width).
REQ-017 DELAY SHALL count D cycles, then enter ACTIVE with o_strob rising at that edge.
REQ-018 o_cnt SHALL increment by 1 on the edge where o_strob rises; 16-bit wrap 0xFFFF -> 0x0000.
REQ-019 After W ACTIVE cycles: o_strob low, o_done high exactly one cycle (first cycle o_strob is low), state to GAP, or IDLE if P_GAP == 0.
REQ-020 GAP SHALL last P_GAP cycles with o_busy high, then IDLE; start in GAP ignored.
REQ-021 Start in DELAY SHALL be ignored; start in ACTIVE per REQ-028/REQ-029.
REQ-022 i_abort high in any state SHALL force IDLE at next edge: o_strob low, o_busy low, no o_done, o_cnt unchanged.
REQ-023 i_abort and i_start_str high in the same IDLE cycle: abort wins, start discarded.
REQ-024 Changes on i_delay/i_width after the start edge SHALL not affect the running operation.
REQ-025 D and W SHALL support full range 1..2^CNT_W-1 with no counter overflow or off-by-one.

Reset
REQ-026 irst high SHALL asynchronously force IDLE, o_strob=0, o_busy=0, o_done=0, o_cnt=0, latched values 0.
REQ-027 Reset mid-strobe SHALL drop o_strob immediately (no clock); after release, first start accepted on the first edge with irst low.

Configuration
REQ-028 With STROB_RETRIG_EN defined, start in ACTIVE with i_width != 0 SHALL reload the remaining width with the new i_width so o_strob stays high i_width cycles from the following cycle; o_cnt unchanged; single o_done at final end.
REQ-029 Without STROB_RETRIG_EN, start in ACTIVE SHALL be ignored; retrigger logic absent.

Verification
REQ-030 Reset, then start with D=3, W=5, P_GAP=4 -> o_strob high cycles N+4..N+8, o_done at N+9, o_busy low from N+13, o_cnt=1.
REQ-031 Start with D=0, W=1 -> o_strob high only in N+1, o_done N+2; start with W=0 -> nothing happens.
REQ-032 Start at N, abort at N+5 (D=2, W=10) -> o_strob low from N+6, no o_done, o_cnt=1; abort+start same idle cycle -> no activity.
REQ-033 Second start during GAP and during DELAY -> ignored; start on first IDLE cycle after GAP -> accepted.
REQ-034 STROB_RETRIG_EN: W=4, restart with W=6 in 3rd ACTIVE cycle -> strobe length 9 cycles, one o_done; without macro -> length 4.
REQ-035 Assert irst mid-ACTIVE with o_cnt=0xFFFF preloaded by 65535 strobes -> all outputs 0 immediately; separately verify wrap to 0x0000 on next strobe without reset.
